rr_arb4: RTL
============

Name: rr_arb4

Overview:
- Round-robin arbiter sharing a single resource between 4 requesters.
- Registers a 2-bit grant index and drives the one-hot grant vector through the existing 2-to-4 decoder.
- Sits between four client blocks and the shared resource. The grant is held until the owner drops its request.
- Fairness: the last-granted requester has lowest priority at the next arbitration.

Parameters:
- HOLD_MAX, 16: maximum cycles a grant may be held; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.
- CNT_W, 8: hold-counter width; must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- iClk  input  1  clock; all state changes on its rising edge.
- iRst_n  input  1  reset, asynchronous assert, active-low.
- iReq  input  4  request vector; a requester holds its bit high for the whole transaction.
- oGnt  output  4  one-hot grant; all zero when idle; decoded from oGntIdx and gated by oValid.
- oGntIdx  output  2  index of the current owner; holds its last value when idle.
- oValid  output  1  high while a grant is active.
- oTimeout  output  1  single-cycle pulse on a forced release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (iRst_n=0, asynchronous): state=IDLE, ptr=0, oGnt=0000, oGntIdx=00, oValid=0, oTimeout=0, hold counter=0.
- States: IDLE, GRANT.
- IDLE, iReq==0: remain in IDLE, outputs unchanged.
- IDLE, iReq!=0: search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set bit is the winner w.
  - Next edge: state=GRANT, oGntIdx=w, oValid=1, ptr=w+1 (mod 4, wraps 3->0).
  - Latency from request sampled in IDLE to oGnt: 1 cycle.
- GRANT, iReq[oGntIdx]==1: hold the grant. Requests from other requesters are ignored; there is no preemption.
- GRANT, iReq[oGntIdx]==0: next edge: state=IDLE, oValid=0, oGnt=0000.
  - Exactly one idle bubble occurs between consecutive grants.
- Simultaneous requests: resolved only by ptr order; equal arrival carries no other priority.
- Requester that drops and re-raises in the same IDLE cycle: treated as a new request, subject to ptr order.
- oGnt = dec2to4(oGntIdx) AND {4{oValid}}: purely a function of registers, so glitch-free relative to iReq.
- Reset asserted mid-grant: grant removed immediately (asynchronously); ptr returns to 0.
- iReq is assumed synchronous to iClk. There is no internal synchronizer.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches HOLD_MAX-1 while the owner still requests, the next edge sets state=IDLE, oValid=0, and oTimeout=1 for one cycle.
  - ptr has already advanced past the owner, so the owner cannot monopolise the resource. It must win a fresh arbitration.
  - Normal release and timeout in the same cycle: treated as a normal release, oTimeout=0.
- Not defined: counter logic absent, oTimeout constant 0, HOLD_MAX and CNT_W unused.

Decomposition:
- Shared header arb_defs.vh:
  - NUM_REQ=4, IDX_W=2.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
- Sub-module: existing dec2to4, instantiated once for oGntIdx -> one-hot.
- Round-robin search stays inline as a combinational block in rr_arb4.

Test Plan:
- Reset then iReq=0000 for 10 cycles -> oGnt=0000, oValid=0, oGntIdx=00 throughout.
- iReq=0100 from reset, held 5 cycles, then 0000 -> oGnt=0100 one cycle after request, held while requested, 0000 one cycle after drop, ptr=3.
- iReq=1111 held continuously, each owner drops for one cycle after 3 cycles of grant and re-raises -> grant order 0,1,2,3,0 with one idle bubble between grants.
- From ptr=2, iReq=0011 -> grant 0; then iReq=0010 -> grant 1 (wrap-around order verified).
- Assert iRst_n=0 mid-grant of requester 2 between clock edges -> oGnt=0000 and oValid=0 immediately, without waiting for a clock edge; after release with iReq=0101, grant goes to 0.
- ARB_TIMEOUT_EN, HOLD_MAX=4, iReq=0010 held forever plus iReq[3]=1 -> oGnt=0010 for 4 cycles, oTimeout pulse, then oGnt=1000.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared constants and FSM state type for the rr_arb4 round-robin arbiter.
package rr_arb4_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb4_dec2to4.sv
// 2-to-4 one-hot decoder turning the registered grant index into a grant vector.
module dec2to4
    import rr_arb4_pkg::*;
(
    input  logic [IDX_W-1:0]   iIdx,
    output logic [NUM_REQ-1:0] oDec
);

    always_comb begin
        oDec       = '0;
        oDec[iIdx] = 1'b1;
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter; grant is held until the owner drops its request.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic [NUM_REQ-1:0] iReq,
    output logic [NUM_REQ-1:0] oGnt,
    output logic [IDX_W-1:0]   oGntIdx,
    output logic               oValid,
    output logic               oTimeout
);

    if (HOLD_MAX == 0 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_cfg
        $error("rr_arb4: HOLD_MAX must be 1..255 and below 2**CNT_W");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic [NUM_REQ-1:0] dec;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
`endif

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!found && iReq[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_GRANT;
                    idx_d   = win;
                    valid_d = 1'b1;
                    ptr_d   = win + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!iReq[idx_q]) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    dec2to4 u_dec (
        .iIdx (idx_q),
        .oDec (dec)
    );

    assign oGnt    = dec & {NUM_REQ{valid_q}};
    assign oGntIdx = idx_q;
    assign oValid  = valid_q;

`ifdef ARB_TIMEOUT_EN
    assign oTimeout = timeout_q;
`else
    assign oTimeout = 1'b0;
`endif

endmodule
